// File: rtl/matrix_mult_sequencer.sv
// Operand loader / result capture sequencer for the 3x3 matrix_mult datapath.
// Optional WAIT watchdog is enabled by defining MMS_TIMEOUT_EN.
//
// state  | meaning
// LOAD_A | accepting a0..a8
// LOAD_B | accepting b0..b8
// START  | one-cycle mm_start pulse
// WAIT   | waiting for mm_done (watchdog runs here when enabled)
// DONE   | result buffer valid, next byte begins a new load as a0
// ERROR  | watchdog expired, next byte clears error and begins a new load as a0
module matrix_mult_sequencer #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                mm_start,
  output logic [9*DATA_W-1:0] mm_a_flat,
  output logic [9*DATA_W-1:0] mm_b_flat,
  input  logic                mm_done,
  input  logic [9*DATA_W-1:0] mm_c_flat,
  input  logic [3:0]          rd_idx,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                result_valid,
  output logic                error
);

  typedef enum logic [2:0] {
    S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        count;
  logic [DATA_W-1:0] a_mem      [9];
  logic [DATA_W-1:0] b_mem      [9];
  logic [DATA_W-1:0] result_buf [9];
  logic              timeout_hit;
  logic              last_byte;

  assign last_byte = (count == 4'd8);

`ifdef MMS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] timer;
  logic          error_q;
  assign timeout_hit = (timer == TIMER_MAX);
  assign error       = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mm_start  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_nxt = S_START;
      end
      S_START: begin
        mm_start  = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // a done arriving on the expiry cycle still wins
        if (mm_done)          state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ERROR;
      end
      S_DONE, S_ERROR: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LOAD_A;
      end
      default: state_nxt = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      result_valid <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        a_mem[i]      <= '0;
        b_mem[i]      <= '0;
        result_buf[i] <= '0;
      end
`ifdef MMS_TIMEOUT_EN
      timer   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD_A: if (in_valid) begin
          a_mem[count] <= in_data;
          count        <= last_byte ? 4'd0 : count + 4'd1;
        end
        S_LOAD_B: if (in_valid) begin
          b_mem[count] <= in_data;
          count        <= last_byte ? 4'd0 : count + 4'd1;
        end
        S_START: begin
`ifdef MMS_TIMEOUT_EN
          timer <= '0;
`endif
        end
        S_WAIT: begin
`ifdef MMS_TIMEOUT_EN
          timer <= timer + 1'b1;
`endif
          if (mm_done) begin
            for (int i = 0; i < 9; i++)
              result_buf[i] <= mm_c_flat[i*DATA_W +: DATA_W];
            result_valid <= 1'b1;
          end else if (timeout_hit) begin
            result_valid <= 1'b0;
`ifdef MMS_TIMEOUT_EN
            error_q <= 1'b1;
`endif
          end
        end
        S_DONE, S_ERROR: if (in_valid) begin
          a_mem[0]     <= in_data;
          count        <= 4'd1;
          result_valid <= 1'b0;
`ifdef MMS_TIMEOUT_EN
          error_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_flat
    assign mm_a_flat[g*DATA_W +: DATA_W] = a_mem[g];
    assign mm_b_flat[g*DATA_W +: DATA_W] = b_mem[g];
  end

  assign rd_data = (rd_idx <= 4'd8) ? result_buf[rd_idx] : '0;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed bench for matrix_mult_sequencer with a behavioural 3x3 multiplier.
// Timeout scenario is exercised only when MMS_TIMEOUT_EN is defined (TIMEOUT_CYC=16).
module tb_matrix_mult_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mm_start;
  logic [71:0]   mm_a_flat, mm_b_flat, mm_c_flat;
  logic          mm_done;
  logic [3:0]    rd_idx;
  logic [DW-1:0] rd_data;
  logic          busy, result_valid, error;

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;   // 0: single done pulse, 1: done held 10 cycles, 2: never done
  int dly      = 0;
  int hold     = 0;
  int starts;
  int acc;

  matrix_mult_sequencer #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mm_start(mm_start), .mm_a_flat(mm_a_flat), .mm_b_flat(mm_b_flat),
    .mm_done(mm_done), .mm_c_flat(mm_c_flat), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .result_valid(result_valid), .error(error)
  );

  always #5 clk = ~clk;

  // behavioural multiplier: answers a few cycles after mm_start
  always @(posedge clk) begin
    if (mm_start && mode != 2) dly <= 3;
    else if (dly > 0)          dly <= dly - 1;
    if (dly == 1)              hold <= (mode == 1) ? 10 : 1;
    else if (hold > 0)         hold <= hold - 1;
  end
  assign mm_done = (hold > 0);

  always_comb begin
    mm_c_flat = '0;
    acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        acc = 0;
        for (int k = 0; k < 3; k++)
          acc = acc + int'(mm_a_flat[(i*3+k)*8 +: 8]) * int'(mm_b_flat[(k*3+j)*8 +: 8]);
        mm_c_flat[(i*3+j)*8 +: 8] = acc[7:0];
      end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_stream(input logic [7:0] bytes [18]);
    in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_data = bytes[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !result_valid; i++) begin
      step();
      if (mm_start) starts++;
    end
    chk("done_seen", result_valid, 1'b1);
  endtask

  logic [7:0] seq1 [18] = '{1,2,3,4,5,6,7,8,9, 9,8,7,6,5,4,3,2,1};
  logic [7:0] seq2 [18] = '{2,0,0,0,2,0,0,0,2, 1,2,3,4,5,6,7,8,9};
  logic [7:0] exp1 [9]  = '{30,24,18,84,69,54,138,114,90};
  logic [7:0] exp2 [9]  = '{2,4,6,8,10,12,14,16,18};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rd_idx = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mm_start", mm_start, 1'b0);
    chk("rst_error", error, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      chk($sformatf("rst_rd_data[%0d]", i), rd_data, 8'd0);
    end

    // full load, start pulse, flats
    mode = 0;
    send_stream(seq1);
    chk("start_after_b8", mm_start, 1'b1);
    chk("busy_in_start", busy, 1'b1);
    chk("in_ready_start", in_ready, 1'b0);
    chk("a_flat", mm_a_flat, 72'h090807060504030201);
    chk("b_flat", mm_b_flat, 72'h010203040506070809);

    // byte offered during WAIT must be held off
    step();
    in_valid = 1'b1; in_data = 8'hFF; #1;
    chk("start_single", mm_start, 1'b0);
    chk("in_ready_wait", in_ready, 1'b0);
    starts = 0;
    wait_done();
    in_valid = 1'b0;
    chk("no_restart_wait", starts, 0);
    chk("a_flat_kept", mm_a_flat, 72'h090807060504030201);
    chk("b_flat_kept", mm_b_flat, 72'h010203040506070809);
    chk("busy_done", busy, 1'b0);
    for (int i = 0; i < 9; i++) begin
      rd_idx = 4'(i); #1;
      chk($sformatf("res1[%0d]", i), rd_data, exp1[i]);
    end
    rd_idx = 4'd9; #1;
    chk("rd_idx9", rd_data, 8'd0);

    // level-held done: one capture, no restart
    mode = 1;
    send_stream(seq1);
    starts = 0;
    wait_done();
    for (int i = 0; i < 12; i++) begin
      step();
      if (mm_start || busy) starts++;
    end
    chk("level_no_restart", starts, 0);
    chk("level_still_valid", result_valid, 1'b1);
    in_valid = 1'b1; in_data = 8'h05;
    step();
    in_valid = 1'b0;
    chk("next_clears_valid", result_valid, 1'b0);
    chk("next_a0", mm_a_flat[7:0], 8'h05);
    rd_idx = 4'd0; #1;
    chk("buf_kept", rd_data, 8'd30);

    // reset after a partial load of 5 bytes
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_a_flat", mm_a_flat, 72'h0);
    chk("midrst_valid", result_valid, 1'b0);
    chk("midrst_rd0", rd_data, 8'd0);
    mode = 0;
    send_stream(seq2);
    chk("reload_start", mm_start, 1'b1);
    wait_done();
    for (int i = 0; i < 9; i++) begin
      rd_idx = 4'(i); #1;
      chk($sformatf("res2[%0d]", i), rd_data, exp2[i]);
    end

`ifdef MMS_TIMEOUT_EN
    mode = 2;
    send_stream(seq1);
    for (int i = 0; i < 16; i++) step();
    chk("to_not_yet", error, 1'b0);
    step();
    chk("to_error", error, 1'b1);
    chk("to_valid", result_valid, 1'b0);
    chk("to_in_ready", in_ready, 1'b1);
    rd_idx = 4'd0; #1;
    chk("to_buf_kept", rd_data, 8'd2);
    in_valid = 1'b1; in_data = 8'h07;
    step();
    in_valid = 1'b0;
    chk("to_cleared", error, 1'b0);
    chk("to_a0", mm_a_flat[7:0], 8'h07);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
